// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: sends a WIDTH-bit word MSB first, each bit
// held BIT_CYCLES clocks, with a strobe on the last cycle of every bit.
module piso_serializer #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             data,
   output logic             shift_enable,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

   generate
      if (WIDTH < 2) begin : gBadWidth
         $error("piso_serializer: WIDTH must be >= 2");
      end
      if (BIT_CYCLES < 1) begin : gBadBitCycles
         $error("piso_serializer: BIT_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bitCnt_q, bitCnt_d;
   logic [CW-1:0]    cycCnt_q, cycCnt_d;
   logic             done_q, done_d;
   logic             bitEnd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitCnt_q <= '0;
         cycCnt_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitCnt_q <= bitCnt_d;
         cycCnt_q <= cycCnt_d;
         done_q   <= done_d;
      end
   end

   // Counters stop at their maximum: the bit ends (and the cycle counter clears)
   // exactly when the cycle counter reaches BIT_CYCLES-1.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitCnt_d = bitCnt_q;
      cycCnt_d = cycCnt_q;
      done_d   = 1'b0;
      bitEnd   = (state_q == SHIFT) && (cycCnt_q == CYC_LAST);
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               shreg_d  = tx_data;
               bitCnt_d = '0;
               cycCnt_d = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (bitEnd) begin
               if (bitCnt_q == BIT_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                  bitCnt_d = bitCnt_q + BW'(1);
                  cycCnt_d = '0;
               end
            end else begin
               cycCnt_d = cycCnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode from state so an asynchronous reset silences them at once.
   always_comb begin
      tx_ready     = (state_q == IDLE);
      busy         = (state_q == SHIFT);
      data         = (state_q == SHIFT) && shreg_q[WIDTH-1];
      shift_enable = bitEnd;
      done         = done_q;
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range WIDTH >= 2.
REQ-002 Parameter BIT_CYCLES, default 1: clk cycles each serial bit is held; legal range BIT_CYCLES >= 1.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tx_data  input  WIDTH  parallel word to transmit; sampled only on the accept edge.
REQ-006 tx_valid  input  1  tx_data is valid; a word is accepted on a rising clk edge where tx_valid=1 and tx_ready=1.
REQ-007 tx_ready  output  1  block can accept a word; high exactly when the FSM is in IDLE.
REQ-008 data  output  1  serial bit, MSB first.
REQ-009 shift_enable  output  1  one-cycle strobe; the receiver samples data on the edge ending this cycle.
REQ-010 busy  output  1  high while a frame is in progress (SHIFT state).
REQ-011 done  output  1  one-cycle pulse after the final bit of a frame.

Function
REQ-012 The block SHALL contain a two-state FSM, IDLE and SHIFT, a WIDTH-bit holding shift register, a bit counter (0..WIDTH-1) and a cycle counter (0..BIT_CYCLES-1).
REQ-013 IDLE: tx_ready=1, busy=0, data=0, shift_enable=0.
REQ-014 On accept (edge N), tx_data SHALL be copied into the holding register, both counters cleared, and the FSM moved to SHIFT.
REQ-015 First serial bit latency: in cycle N+1, data SHALL equal tx_data[WIDTH-1] as captured at edge N.
REQ-016 In SHIFT, data SHALL equal the holding register MSB; each bit SHALL be held for exactly BIT_CYCLES consecutive cycles.
REQ-017 shift_enable SHALL be 1 only in the last cycle of each bit period (cycle counter = BIT_CYCLES-1), giving exactly WIDTH strobes per frame.
REQ-018 On each shift_enable edge that is not the last bit, the holding register SHALL shift left by one (zero fill), the bit counter SHALL increment, and the cycle counter SHALL clear.
REQ-019 On the shift_enable edge of bit WIDTH-1, the FSM SHALL return to IDLE and done SHALL be registered high for exactly the following cycle.
REQ-020 A frame SHALL occupy exactly WIDTH*BIT_CYCLES cycles in SHIFT.
REQ-021 A word offered while done=1 SHALL be accepted (the FSM is in IDLE); back-to-back frames SHALL be separated by exactly one IDLE cycle.
REQ-022 While busy=1, tx_valid SHALL be ignored, tx_ready SHALL be 0, and changes on tx_data SHALL NOT affect the frame in progress.
REQ-023 Bit order SHALL be MSB first, so that an 8-bit left-shifting receiver clocked by shift_enable holds the original word after 8 strobes.
REQ-024 Counter widths SHALL be sized with clog2 of their range; neither counter SHALL wrap past its maximum value.
REQ-025 Illegal parameter values SHALL be rejected at elaboration.

Reset
REQ-026 While reset=1, the block SHALL be in the following state: FSM=IDLE; holding register, both counters, data, shift_enable, busy and done all 0; tx_ready=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with no done pulse and no further shift_enable.
REQ-028 After reset deasserts, the first accept SHALL start a clean frame from bit WIDTH-1.

Verification
REQ-029 Basic frame: WIDTH=8, BIT_CYCLES=1, accept 8'hA5.
- data SHALL be 1,0,1,0,0,1,0,1 across 8 consecutive shift_enable cycles.
- done SHALL pulse in the 9th cycle after accept.
- A looped-back SIPO SHALL hold 8'hA5.
REQ-030 Stretched bits: BIT_CYCLES=3, accept 8'h81.
- Each bit SHALL be held 3 cycles, with shift_enable high on the 3rd cycle only.
- busy SHALL be high for 24 cycles; the serial pattern SHALL be 1,0,0,0,0,0,0,1.
REQ-031 Back-to-back: tx_valid held high with 8'hFF, then 8'h00 presented after the first accept.
- The second word SHALL be accepted in the done cycle.
- Exactly one idle cycle with shift_enable=0 SHALL separate the frames.
REQ-032 Busy interference: during a frame of 8'h3C, toggle tx_valid and change tx_data to 8'hC3.
- tx_ready SHALL stay 0.
- The serial output SHALL still be 0,0,1,1,1,1,0,0.
REQ-033 Mid-frame reset: assert reset during bit 4 of 8'hF0.
- data, shift_enable and busy SHALL go to 0 immediately; done SHALL stay 0.
- A subsequent 8'h5A frame SHALL transmit correctly.
